// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction split/align, next-PC prediction,
// and the F/D pipeline register.
module fetch_stage #(
  parameter int          ADDR_W = 64,
  parameter logic [3:0]  RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] PC_o,
  input  logic [79:0]       instr,
  input  logic              imem_error,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [3:0]        W_icode,
  input  logic [ADDR_W-1:0] W_valM,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  output logic [2:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [63:0]       D_valC,
  output logic [ADDR_W-1:0] D_valP
);

  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_JXX = 4'h7,
                         I_CALL = 4'h8, I_RET = 4'h9;
  localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;

  logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
  logic [ADDR_W-1:0] f_pc, f_valp;
  logic [3:0]        f_icode, f_ifun, f_ra, f_rb;
  logic [63:0]       valc_raw, f_valc;
  logic [2:0]        f_stat;
  logic              instr_valid, need_regids, need_valc;

  always_comb begin
    if (M_icode == I_JXX && !M_Cnd) f_pc = M_valA;
    else if (W_icode == I_RET)      f_pc = W_valM;
    else                            f_pc = pred_pc_q;
  end
  assign PC_o = f_pc;

  assign f_icode = imem_error ? I_NOP : instr[79:76];
  assign f_ifun  = imem_error ? 4'h0  : instr[75:72];

  assign instr_valid = (f_icode <= 4'hB);

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (f_icode)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
      default: need_regids = 1'b0;
    endcase
    case (f_icode)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
      default: need_valc = 1'b0;
    endcase
  end

  assign f_ra = need_regids ? instr[71:68] : RNONE;
  assign f_rb = need_regids ? instr[67:64] : RNONE;

  // Byte k of the window sits at instr[79-8k -: 8]; the constant starts at byte 1 or 2.
  for (genvar gi = 0; gi < 8; gi++) begin : g_valc
    assign valc_raw[8*gi +: 8] = need_regids ? instr[79-8*(gi+2) -: 8]
                                             : instr[79-8*(gi+1) -: 8];
  end
  assign f_valc = need_valc ? valc_raw : 64'd0;

  assign f_valp = f_pc + ADDR_W'(1) + ADDR_W'(need_regids) + (need_valc ? ADDR_W'(8) : ADDR_W'(0));

  assign pred_pc_d = (f_icode == I_JXX || f_icode == I_CALL) ? ADDR_W'(f_valc) : f_valp;

  always_comb begin
    if (imem_error)             f_stat = S_ADR;
    else if (!instr_valid)      f_stat = S_INS;
    else if (f_icode == I_HALT) f_stat = S_HLT;
    else                        f_stat = S_AOK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        pred_pc_q <= '0;
    else if (!F_stall) pred_pc_q <= pred_pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (!D_stall && D_bubble)) begin
      D_stat  <= S_AOK;
      D_icode <= I_NOP;
      D_ifun  <= 4'h0;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      D_stat  <= f_stat;
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_ra;
      D_rB    <= f_rb;
      D_valC  <= f_valc;
      D_valP  <= f_valp;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expected values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] PC_o;
  logic [79:0] instr;
  logic        imem_error;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic        F_stall, D_stall, D_bubble;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .PC_o(PC_o), .instr(instr), .imem_error(imem_error),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, " stat"},  64'(D_stat),  64'd1);
    check({tag, " icode"}, 64'(D_icode), 64'h1);
    check({tag, " ifun"},  64'(D_ifun),  64'h0);
    check({tag, " rA"},    64'(D_rA),    64'hF);
    check({tag, " rB"},    64'(D_rB),    64'hF);
    check({tag, " valC"},  D_valC,       64'h0);
    check({tag, " valP"},  D_valP,       64'h0);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; imem_error = 1'b0;
    M_icode = 4'h1; M_Cnd = 1'b0; M_valA = '0;
    W_icode = 4'h1; W_valM = '0;
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    tick(); tick();
    check_bubble("reset");
    check("reset PC", PC_o, 64'h0);

    // irmovq $0x100,%rax at PC 0
    rst_n = 1'b1;
    instr = 80'h30F00001000000000000;
    #1 check("irmovq fpc", PC_o, 64'h0);
    tick();
    check("irmovq icode", 64'(D_icode), 64'h3);
    check("irmovq rA",    64'(D_rA),    64'hF);
    check("irmovq rB",    64'(D_rB),    64'h0);
    check("irmovq valC",  D_valC,       64'h100);
    check("irmovq valP",  D_valP,       64'h0A);
    check("irmovq stat",  64'(D_stat),  64'd1);
    check("irmovq PC",    PC_o,         64'h0A);

    // jmp 0x20 at PC 0x0A
    instr = 80'h70200000000000000000;
    tick();
    check("jmp icode", 64'(D_icode), 64'h7);
    check("jmp valP",  D_valP,       64'h13);
    check("jmp valC",  D_valC,       64'h20);
    check("jmp rA",    64'(D_rA),    64'hF);
    check("jmp rB",    64'(D_rB),    64'hF);
    check("jmp PC",    PC_o,         64'h20);

    // PC select priority, combinational
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h13;
    #1 check("sel mispredict", PC_o, 64'h13);
    M_icode = 4'h1; W_icode = 4'h9; W_valM = 64'h40;
    #1 check("sel ret", PC_o, 64'h40);
    M_icode = 4'h7;
    #1 check("sel both", PC_o, 64'h13);
    M_Cnd = 1'b1;
    #1 check("sel taken+ret", PC_o, 64'h40);
    M_icode = 4'h1; M_Cnd = 1'b0; W_icode = 4'h1;
    #1 check("sel pred", PC_o, 64'h20);

    // invalid icode C at PC 0x20
    instr = 80'hC0000000000000000000;
    tick();
    check("ins stat",  64'(D_stat),  64'd4);
    check("ins icode", 64'(D_icode), 64'hC);
    check("ins valP",  D_valP,       64'h21);

    // memory error at PC 0x21
    imem_error = 1'b1;
    tick();
    check("adr stat",  64'(D_stat),  64'd3);
    check("adr icode", 64'(D_icode), 64'h1);
    check("adr valP",  D_valP,       64'h22);
    imem_error = 1'b0;

    // halt at PC 0x22
    instr = 80'h00000000000000000000;
    tick();
    check("hlt stat",  64'(D_stat),  64'd2);
    check("hlt icode", 64'(D_icode), 64'h0);
    check("hlt valP",  D_valP,       64'h23);
    check("hlt PC",    PC_o,         64'h23);

    // F_stall for two cycles at PC 0x23 with a nop
    instr = 80'h10000000000000000000;
    F_stall = 1'b1;
    tick();
    check("fstall PC 1", PC_o, 64'h23);
    tick();
    check("fstall PC 2", PC_o, 64'h23);
    check("fstall valP", D_valP, 64'h24);
    F_stall = 1'b0;

    // addq %rax,%rcx at PC 0x23
    instr = 80'h60010000000000000000;
    tick();
    check("opq icode", 64'(D_icode), 64'h6);
    check("opq rA",    64'(D_rA),    64'h0);
    check("opq rB",    64'(D_rB),    64'h1);
    check("opq valP",  D_valP,       64'h25);

    // D_stall holds while F advances over irmovq at 0x25
    instr = 80'h30F21122334455667788;
    D_stall = 1'b1;
    tick();
    check("dstall icode", 64'(D_icode), 64'h6);
    check("dstall valP",  D_valP,       64'h25);
    check("dstall rB",    64'(D_rB),    64'h1);
    check("dstall PC",    PC_o,         64'h2F);

    D_bubble = 1'b1;
    tick();
    check("stall+bubble icode", 64'(D_icode), 64'h6);
    check("stall+bubble valP",  D_valP,       64'h25);

    D_stall = 1'b0;
    tick();
    check_bubble("bubble");
    check("bubble PC", PC_o, 64'h43);
    D_bubble = 1'b0;

    // irmovq with distinct constant bytes at 0x43
    tick();
    check("valC order", D_valC,      64'h8877665544332211);
    check("valC rB",    64'(D_rB),   64'h2);
    check("valC valP",  D_valP,      64'h4D);

    // valP wrap-around via mispredict redirect
    M_icode = 4'h7; M_valA = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    check("wrap valP", D_valP, 64'h8);
    M_icode = 4'h1;
    #1 check("wrap PC", PC_o, 64'h8);

    // reset mid-stream overrides stalls
    F_stall = 1'b1; D_stall = 1'b1; rst_n = 1'b0;
    tick();
    check("midrst PC", PC_o, 64'h0);
    check_bubble("midrst");
    rst_n = 1'b1; F_stall = 1'b0; D_stall = 1'b0;
    #1 check("release PC", PC_o, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the pipelined Y86-64 core, directly upstream of the decode stage.
- Selects the fetch PC and drives it to the instruction memory, which returns a combinational 80-bit window plus an `imem_error` flag.
- Splits and aligns the returned bytes, computes `valP`, predicts the next PC and holds it in the F register.
- Registers the fetched fields into the F/D pipeline register, with stall and bubble control from the pipeline control logic.

Parameters:
- ADDR_W, 64, PC/address width.
- RNONE, 4'hF, register-ID encoding for "no register".

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- PC_o  out  64  fetch address to instruction memory (combinational `f_pc`).
- instr  in  80  instruction window; [79:72] = byte at PC, [7:0] = byte at PC+9.
- imem_error  in  1  instruction memory address error for PC_o.
- M_icode  in  4  icode in memory stage.
- M_Cnd  in  1  branch condition in memory stage.
- M_valA  in  64  fall-through PC of a mispredicted jump.
- W_icode  in  4  icode in write-back stage.
- W_valM  in  64  return address popped by RET.
- F_stall  in  1  hold F register.
- D_stall  in  1  hold F/D register.
- D_bubble  in  1  load bubble into F/D register.
- D_stat  out  3  status: AOK=1, HLT=2, ADR=3, INS=4.
- D_icode  out  4  registered icode.
- D_ifun  out  4  registered ifun.
- D_rA  out  4  registered rA.
- D_rB  out  4  registered rB.
- D_valC  out  64  registered constant word.
- D_valP  out  64  registered incremented PC.

Behaviour:
- Icodes: HALT 0, NOP 1, CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
- `f_pc` (combinational), priority order:
  - `M_icode==7 && !M_Cnd` → `M_valA`;
  - else `W_icode==9` → `W_valM`;
  - else `F_predPC`.
  - `PC_o = f_pc`.
- Split: `byte0 = instr[79:72]`.
  - If `imem_error`: icode=1, ifun=0 (forced NOP).
  - Otherwise: icode = byte0[7:4], ifun = byte0[3:0].
- Flags:
  - `instr_valid` = icode ≤ 4'hB.
  - `need_regids` = icode ∈ {2,3,4,5,6,A,B}.
  - `need_valC` = icode ∈ {3,4,5,7,8}.
- Registers and constant:
  - If `need_regids`: rA = instr[71:68], rB = instr[67:64]; otherwise rA = rB = RNONE.
  - valC is a little-endian 8-byte word starting at byte 1+need_regids: lowest-addressed byte becomes valC[7:0].
  - If `!need_valC`, valC = 0.
- `valP = f_pc + 1 + need_regids + 8*need_valC`, modulo 2^64 (wraps silently).
- `predPC` = valC if icode ∈ {7,8}, else valP.
- `f_stat` priority order: `imem_error` → ADR; else `!instr_valid` → INS; else icode==0 → HLT; else AOK.
- F register:
  - Reset → `F_predPC = 0`.
  - `F_stall` → hold.
  - Else → `predPC`.
- F/D register, priority reset > D_stall > D_bubble > load:
  - Reset and bubble value: stat=1, icode=1, ifun=0, rA=rB=F, valC=0, valP=0.
  - D_stall holds all D outputs, and wins if D_bubble is asserted in the same cycle.
  - Load captures f_stat, icode, ifun, rA, rB, valC, valP.
- Reset mid-operation: both registers take reset values on the next edge regardless of stall/bubble.
- Next cycle after release: PC_o = 0, provided M_icode/W_icode do not select.
- No internal halt latch: the fetch stage keeps fetching after HLT/ADR/INS; stopping is the control logic's job via F_stall.
- Latency: combinational from inputs to PC_o; one cycle from fetch to D_* outputs.

Test Plan:
- Reset, then bytes 30 F0 00 01 00 00 00 00 00 00 at PC 0 (irmovq $0x100,%rax), next edge → D_icode=3, D_rA=F, D_rB=0, D_valC=0x100, D_valP=0x0A, D_stat=1; PC_o=0x0A.
- Bytes 70 20 00 00 00 00 00 00 00 at PC 0x0A (jmp 0x20) → D_valP=0x13, D_rA=D_rB=F, next PC_o=0x20.
- Select priority:
  - M_icode=7, M_Cnd=0, M_valA=0x13 → PC_o=0x13 in same cycle.
  - W_icode=9, W_valM=0x40 with M_icode=1 → PC_o=0x40.
  - Both asserted → M_valA wins.
- Status:
  - Byte0=0xC0 → D_stat=4, D_icode=C.
  - imem_error=1 → D_stat=3, D_icode=1.
  - Byte0=0x00 → D_stat=2, D_valP=f_pc+1.
- Control:
  - F_stall=1 for 2 cycles → PC_o constant.
  - D_stall=1 → D_* unchanged.
  - D_bubble=1 → D_icode=1, D_stat=1, D_rA=F.
  - D_stall=D_bubble=1 → hold.
- Reset asserted mid-stream with F_stall=1 and D_stall=1 → after the edge, PC_o=0, D_* equal the bubble values.
